// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch sequencer.
//   state_t    - fetch FSM state encoding
//   PC_W       - program counter / address width
//   WORD_BYTES - bytes per instruction word
//   BYTE_W     - width of one memory byte lane
//   pc_oob()   - true when no full word can start at pc
package fetch_pkg;

    localparam int PC_W       = 32;
    localparam int WORD_BYTES = 4;
    localparam int BYTE_W     = 8;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_FAULT = 2'd2
    } state_t;

    // A word starting at pc runs past the end of memory when pc exceeds
    // the last legal word address. Checked before pc+cnt can wrap.
    function automatic logic pc_oob(input logic [PC_W-1:0] pc, input int mem_bytes);
        return pc > PC_W'(mem_bytes - WORD_BYTES);
    endfunction

endpackage

// File: rtl/fetch_word_asm.sv
// fetch_word_asm: byte-lane word assembly register.
//   clk, rst_n - clock, async active-low reset
//   clr        - zero all lanes (discard a partial word)
//   ld         - write din into the lane picked by sel
//   sel        - byte index within the word; 0 lands in the top lane (big-endian)
//   din        - byte to capture
//   dout       - assembled word
module fetch_word_asm
    import fetch_pkg::*;
#(
    parameter int NUM_LANES = WORD_BYTES,
    parameter int VEC_W     = BYTE_W,
    localparam int SEL_W    = $clog2(NUM_LANES)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       ld,
    input  logic [SEL_W-1:0]           sel,
    input  logic [VEC_W-1:0]           din,
    output logic [NUM_LANES*VEC_W-1:0] dout
);

    logic [NUM_LANES-1:0][VEC_W-1:0] lanes;
    logic [SEL_W-1:0]                lane_idx;

    // Byte 0 of the word belongs in the most significant lane.
    assign lane_idx = SEL_W'(NUM_LANES - 1) - sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lanes <= '0;
        end else if (clr) begin
            lanes <= '0;
        end else if (ld) begin
            lanes[lane_idx] <= din;
        end
    end

    assign dout = lanes;

endmodule

// File: rtl/fetch_seq.sv
// fetch_seq: instruction fetch sequencer. Owns the PC, reads one byte per
// cycle from a combinational instruction memory, assembles big-endian
// 32-bit words and hands them to decode over valid/ready.
//   clk, rst_n           - clock, async active-low reset
//   mem_addr, mem_rd     - byte address (pc+cnt) and capture strobe to memory
//   mem_data             - byte returned combinationally for mem_addr
//   ins_out, ins_pc      - assembled word and its address
//   ins_valid, ins_ready - handshake with decode
//   redirect, redirect_pc- PC load from branch/jump logic, highest priority
//   fault                - sticky stop on out-of-range or misaligned PC
module fetch_seq
    import fetch_pkg::*;
#(
    parameter int          MEM_BYTES = 1000,
    parameter logic [31:0] RESET_PC  = 32'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] mem_addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_data,
    output logic [31:0] ins_out,
    output logic [31:0] ins_pc,
    output logic        ins_valid,
    input  logic        ins_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        fault
);

    state_t          state, state_n;
    logic [PC_W-1:0] pc, pc_n, ins_pc_n;
    logic [1:0]      cnt, cnt_n;
    logic            ins_valid_n, fault_n;
    logic            oob;

    assign oob = pc_oob(pc, MEM_BYTES);

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_FETCH;
            pc        <= RESET_PC;
            cnt       <= 2'd0;
            ins_pc    <= RESET_PC;
            ins_valid <= 1'b0;
            fault     <= 1'b0;
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            cnt       <= cnt_n;
            ins_pc    <= ins_pc_n;
            ins_valid <= ins_valid_n;
            fault     <= fault_n;
        end
    end

    // Next-state logic. Redirect overrides everything, including a
    // handshake in the same cycle: the held word is still consumed, but the
    // new PC comes from redirect_pc rather than pc+4.
    always_comb begin
        state_n     = state;
        pc_n        = pc;
        cnt_n       = cnt;
        ins_pc_n    = ins_pc;
        ins_valid_n = ins_valid;
        fault_n     = fault;
        if (redirect) begin
            pc_n        = redirect_pc;
            cnt_n       = 2'd0;
            ins_valid_n = 1'b0;
            fault_n     = |redirect_pc[1:0];
            state_n     = fault_n ? S_FAULT : S_FETCH;
        end else begin
            case (state)
                S_FETCH: begin
                    if (cnt == 2'd0 && oob) begin
                        state_n = S_FAULT;
                        fault_n = 1'b1;
                    end else begin
                        cnt_n = cnt + 2'd1;
                        if (cnt == 2'd3) begin
                            cnt_n       = 2'd0;
                            ins_pc_n    = pc;
                            ins_valid_n = 1'b1;
                            state_n     = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (ins_valid && ins_ready) begin
                        pc_n        = pc + PC_W'(WORD_BYTES);
                        ins_valid_n = 1'b0;
                        state_n     = S_FETCH;
                    end
                end
                S_FAULT: begin
                    // parked until a redirect
                end
                default: begin
                    state_n = S_FAULT;
                    fault_n = 1'b1;
                end
            endcase
        end
    end

    // Memory port. A capture happens only in S_FETCH, never on a redirect
    // cycle and never for a word that would start past the end of memory.
    always_comb begin
        mem_addr = pc + PC_W'(cnt);
        mem_rd   = 1'b0;
        if (!redirect && state == S_FETCH && !(cnt == 2'd0 && oob))
            mem_rd = 1'b1;
    end

    fetch_word_asm #(
        .NUM_LANES (WORD_BYTES),
        .VEC_W     (BYTE_W)
    ) u_asm (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (redirect),
        .ld    (mem_rd),
        .sel   (cnt),
        .din   (mem_data),
        .dout  (ins_out)
    );

endmodule
